fetch_sequencer: RTL
====================

# fetch_sequencer

Instruction-fetch sequencer for the TB4004 core, directly downstream of the 8-phase cycle generator. It consumes the `cycle` count (0–7 = A1, A2, A3, M1, M2, X1, X2, X3) and the `sync` pulse. During A1–A3 it drives the 12-bit program address onto the 4-bit bus, one nibble per phase. During M1/M2 it captures the OPR/OPA nibbles. It assembles one-word and two-word instructions and hands them to the decoder with a single-cycle valid strobe.

## Interface
- No parameters.
- `toggle_clk` input 1 — core clock, the same clock that advances `cycle`; all state updates on its rising edge.
- `rst` input 1 — asynchronous, active-high reset.
- `cycle` input 3 — current phase from the cycle generator.
- `sync` input 1 — high during X3 (`cycle`==7).
- `pc_in` input 12 — program counter value to fetch from next.
- `data_in` input 4 — ROM bus read data.
- `data_out` output 4 — bus drive value.
- `data_oe` output 1 — bus drive enable.
- `opr` output 4 — first-word high nibble.
- `opa` output 4 — first-word low nibble.
- `opr2` output 4 — second-word high nibble (two-word instructions only).
- `opa2` output 4 — second-word low nibble (two-word instructions only).
- `two_word` output 1 — the instruction presented with `instr_valid` is two-word.
- `instr_valid` output 1 — one-clock strobe: the instruction fields are complete.
- `pc_inc` output 1 — one-clock strobe: the PC must advance by one word.
- `desync` output 1 — sticky error flag.

## Operation
- **Address latch**
  - `pc_lat`[11:0] captures `pc_in` on the rising edge where `sync`=1, i.e. the 7→0 transition.
  - `pc_lat` is held unchanged for the whole following instruction cycle.
- **Bus drive** (combinational from `cycle` and `pc_lat`)
  - `cycle`=0: `data_out`=`pc_lat`[3:0].
  - `cycle`=1: `data_out`=`pc_lat`[7:4].
  - `cycle`=2: `data_out`=`pc_lat`[11:8].
  - `data_oe`=1 only for `cycle` 0–2.
  - Otherwise `data_oe`=0 and `data_out`=0.
- **Nibble capture**
  - At the rising edge with `cycle`=3, `data_in` goes into the current word's high-nibble register.
  - At the rising edge with `cycle`=4, `data_in` goes into the current word's low-nibble register.
  - State FIRST captures into `opr`/`opa`.
  - State SECOND captures into `opr2`/`opa2`.
- **State machine** (states FIRST and SECOND), evaluated at the rising edge with `cycle`=4 using the OPR nibble and the incoming `data_in` as OPA:
  - In FIRST, the word is two-word when OPR ∈ {1 JCN, 4 JUN, 5 JMS, 7 ISZ}, or when OPR=2 and OPA[0]=0 (FIM).
    - If two-word: FIRST→SECOND, and `instr_valid` is not asserted.
    - If not two-word: stay in FIRST and assert `instr_valid` with `two_word`=0.
  - In SECOND: go to FIRST and assert `instr_valid` with `two_word`=1.
- **Strobes**
  - `pc_inc` is asserted for every word fetched, including second words.
  - `instr_valid` and `pc_inc` are registered: high exactly while `cycle`=5 (X1).
  - `two_word` is registered alongside `instr_valid`. It holds its value until the next `instr_valid`.
- **Field stability**
  - `opr`/`opa` are not overwritten while in SECOND.
  - All fields stay stable from `instr_valid` until the next capture edge.
- **Desync detection**
  - `desync` is set when, at any rising edge, `sync` ≠ (`cycle`==7).
  - Once set, it stays set until `rst`.
  - Sequencing continues regardless of `desync`.

## Timing
- **Reset** (`rst`=1, asynchronous, any time):
  - State returns to FIRST.
  - `pc_lat`, `opr`, `opa`, `opr2`, `opa2` = 0.
  - `two_word`, `instr_valid`, `pc_inc`, `desync` = 0.
  - `data_oe` and `data_out` follow `cycle`, with `pc_lat`=0.
- **Reset mid-instruction:** any partially assembled two-word instruction is discarded and no strobe is emitted. The first cycle after reset fetches address 0x000.
- **Latency**
  - Single-word instruction: `instr_valid` occurs in X1 of the same instruction cycle, 5 clocks after A1 begins.
  - Two-word instruction: `instr_valid` occurs in X1 of the second instruction cycle, 13 clocks after the first A1.
- **Rate:** at most one `pc_inc` per 8 clocks and at most one `instr_valid` per 8 clocks.
- **PC changes:** a change to `pc_in` outside the 7→0 edge has no effect on the bus until the next `sync` edge.

## Test plan
- **Reset then one-word fetch:** release `rst`, `pc_in`=0x123, data_in=0xD (M1) then 0x5 (M2).
  - Second cycle A1–A3 bus: 3, 2, 1 with `data_oe`=1.
  - X1: `instr_valid`=1, `pc_inc`=1, `two_word`=0, `opr`=0xD, `opa`=0x5.
- **Two-word JUN:** words 0x4A then 0xBC.
  - First X1: `pc_inc`=1, `instr_valid`=0.
  - Second X1: `instr_valid`=1, `two_word`=1, `opr`=4, `opa`=0xA, `opr2`=0xB, `opa2`=0xC.
- **FIM vs SRC:** word 0x22 → two-word. Word 0x23 → one-word, `instr_valid` in the same cycle.
- **Reset mid-instruction:** assert `rst` during `cycle`=6 of the first word of JMS 0x50.
  - No `instr_valid` is ever emitted for it.
  - All outputs read 0 immediately, before any clock edge.
- **Desync:** force `sync`=1 while `cycle`=3 for one edge.
  - `desync`=1 and stays set.
  - Fetch of 0xD5 still yields `instr_valid` in X1.
- **Bus idle:** `data_oe`=0 and `data_out`=0 for `cycle` 3–7 across 16 consecutive cycles with `pc_in`=0xFFF.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Fetch-sequencer bus bundle: phase inputs, ROM bus and decoder-facing fields.
interface fetch_sequencer_if;
    logic [2:0]  cycle;
    logic        sync;
    logic [11:0] pc_in;
    logic [3:0]  data_in;
    logic [3:0]  data_out;
    logic        data_oe;
    logic [3:0]  opr;
    logic [3:0]  opa;
    logic [3:0]  opr2;
    logic [3:0]  opa2;
    logic        two_word;
    logic        instr_valid;
    logic        pc_inc;
    logic        desync;

    // Sequencer side.
    modport master (
        input  cycle, sync, pc_in, data_in,
        output data_out, data_oe, opr, opa, opr2, opa2,
        output two_word, instr_valid, pc_inc, desync
    );

    // Cycle generator / ROM / decoder side.
    modport slave (
        output cycle, sync, pc_in, data_in,
        input  data_out, data_oe, opr, opa, opr2, opa2,
        input  two_word, instr_valid, pc_inc, desync
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: drives the PC onto the nibble bus in A1-A3,
// captures OPR/OPA in M1/M2 and assembles one- or two-word instructions.
module fetch_sequencer (
    input  logic               toggle_clk,
    input  logic               rst,
    fetch_sequencer_if.master  bus
);
    localparam int unsigned NIB_W = 4;
    localparam int unsigned PC_W  = 12;

    localparam logic [2:0] PH_A1 = 3'd0;
    localparam logic [2:0] PH_A2 = 3'd1;
    localparam logic [2:0] PH_A3 = 3'd2;
    localparam logic [2:0] PH_M1 = 3'd3;
    localparam logic [2:0] PH_M2 = 3'd4;
    localparam logic [2:0] PH_X3 = 3'd7;

    typedef enum logic {
        FIRST  = 1'b0,
        SECOND = 1'b1
    } state_t;

    state_t            state;
    logic [PC_W-1:0]   pc_lat;
    logic [NIB_W-1:0]  opr;
    logic [NIB_W-1:0]  opa;
    logic [NIB_W-1:0]  opr2;
    logic [NIB_W-1:0]  opa2;
    logic              two_word;
    logic              instr_valid;
    logic              pc_inc;
    logic              desync;

    // JCN, JUN, JMS, ISZ and FIM (OPR=2 with even OPA) carry a second word.
    function automatic logic is_two_word(input logic [NIB_W-1:0] r, input logic [NIB_W-1:0] a);
        logic res;
        res = 1'b0;
        case (r)
            4'h1, 4'h4, 4'h5, 4'h7: res = 1'b1;
            4'h2:                   res = ~a[0];
            default:                res = 1'b0;
        endcase
        return res;
    endfunction

    // Sequencer state, field capture, strobes and sticky desync flag.
    always_ff @(posedge toggle_clk or posedge rst) begin
        if (rst) begin
            state       <= FIRST;
            pc_lat      <= '0;
            opr         <= '0;
            opa         <= '0;
            opr2        <= '0;
            opa2        <= '0;
            two_word    <= 1'b0;
            instr_valid <= 1'b0;
            pc_inc      <= 1'b0;
            desync      <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            pc_inc      <= 1'b0;

            if (bus.sync != (bus.cycle == PH_X3)) begin
                desync <= 1'b1;
            end

            if (bus.sync) begin
                pc_lat <= bus.pc_in;
            end

            if (bus.cycle == PH_M1) begin
                if (state == FIRST) begin
                    opr <= bus.data_in;
                end else begin
                    opr2 <= bus.data_in;
                end
            end

            if (bus.cycle == PH_M2) begin
                pc_inc <= 1'b1;
                if (state == FIRST) begin
                    opa <= bus.data_in;
                    if (is_two_word(opr, bus.data_in)) begin
                        state <= SECOND;
                    end else begin
                        instr_valid <= 1'b1;
                        two_word    <= 1'b0;
                    end
                end else begin
                    opa2        <= bus.data_in;
                    state       <= FIRST;
                    instr_valid <= 1'b1;
                    two_word    <= 1'b1;
                end
            end
        end
    end

    // Address nibbles driven onto the bus during A1-A3 only.
    always_comb begin
        bus.data_out = '0;
        bus.data_oe  = 1'b0;
        case (bus.cycle)
            PH_A1: begin
                bus.data_out = pc_lat[3:0];
                bus.data_oe  = 1'b1;
            end
            PH_A2: begin
                bus.data_out = pc_lat[7:4];
                bus.data_oe  = 1'b1;
            end
            PH_A3: begin
                bus.data_out = pc_lat[11:8];
                bus.data_oe  = 1'b1;
            end
            default: begin
                bus.data_out = '0;
                bus.data_oe  = 1'b0;
            end
        endcase
    end

    assign bus.opr         = opr;
    assign bus.opa         = opa;
    assign bus.opr2        = opr2;
    assign bus.opa2        = opa2;
    assign bus.two_word    = two_word;
    assign bus.instr_valid = instr_valid;
    assign bus.pc_inc      = pc_inc;
    assign bus.desync      = desync;
endmodule
